logic_arbiter: RTL and testbench

LOGIC_ARBITER -- requirements
Module: logic_arbiter

---
 rtl/logic_arbiter.sv | 150 +++++++++++++++
 tb/tb_logic_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/logic_arbiter.sv
// Round-robin arbiter sharing one logical-op datapath among NUM_REQ requesters.
// A single registered result slot gives one-cycle latency and full throughput.
module logic_arbiter #(
    parameter int SRC_WIDTH     = 32,
    parameter int OUT_WIDTH     = 32,
    parameter int CONTROL_WIDTH = 11,
    parameter int NUM_REQ       = 4,
    parameter int ID_WIDTH      = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*SRC_WIDTH-1:0]     req_src1,
    input  logic [NUM_REQ*SRC_WIDTH-1:0]     req_src2,
    input  logic [NUM_REQ*CONTROL_WIDTH-1:0] req_control,
    output logic                             res_valid,
    input  logic                             res_ready,
    output logic [OUT_WIDTH-1:0]             res_data,
    output logic [ID_WIDTH-1:0]              res_id,
    output logic                             busy
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [ID_WIDTH-1:0]    r_ptr;
    logic [OUT_WIDTH-1:0]   r_data;
    logic [ID_WIDTH-1:0]    r_id;

    logic                   w_can_accept;
    logic                   w_found;
    logic [ID_WIDTH-1:0]    w_gnt_idx;
    logic [NUM_REQ-1:0]     w_gnt;
    logic                   w_xfer;
    logic [SRC_WIDTH-1:0]   w_s1;
    logic [SRC_WIDTH-1:0]   w_s2;
    logic [CONTROL_WIDTH-1:0] w_ctl;
    logic [1:0]             w_op_sel;
    logic [SRC_WIDTH-1:0]   w_op;
    logic [OUT_WIDTH-1:0]   w_res;
    logic                   w_unused;

    function automatic logic [ID_WIDTH-1:0] rr_idx(
        input logic [ID_WIDTH-1:0] base,
        input int                  k
    );
        return ID_WIDTH'((int'(base) + k) % NUM_REQ);
    endfunction

    // Reset masks the grant so nothing can transfer in the reset cycle.
    assign w_can_accept = !rst && ((r_state == EMPTY) || res_ready);

    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && req_valid[rr_idx(r_ptr, k)]) begin
                w_found   = 1'b1;
                w_gnt_idx = rr_idx(r_ptr, k);
            end
        end
    end

    always_comb begin
        w_gnt = '0;
        if (w_found && w_can_accept) begin
            w_gnt[w_gnt_idx] = 1'b1;
        end
    end

    assign req_ready = w_gnt;
    assign w_xfer    = |w_gnt;

    assign w_s1  = req_src1[int'(w_gnt_idx)*SRC_WIDTH +: SRC_WIDTH];
    assign w_s2  = req_src2[int'(w_gnt_idx)*SRC_WIDTH +: SRC_WIDTH];
    assign w_ctl = req_control[int'(w_gnt_idx)*CONTROL_WIDTH +: CONTROL_WIDTH];
    assign w_op_sel = w_ctl[6:5];

    always_comb begin
        w_op = '0;
        unique case (w_op_sel)
            2'd0: w_op = ~w_s2;
            2'd1: w_op = w_s1 & w_s2;
            2'd2: w_op = w_s1 | w_s2;
            2'd3: w_op = w_s1 ^ w_s2;
            default: w_op = '0;
        endcase
    end

    generate
        if (OUT_WIDTH <= SRC_WIDTH) begin : g_trunc
            assign w_res = w_op[OUT_WIDTH-1:0];
        end else begin : g_zext
            assign w_res = {{(OUT_WIDTH-SRC_WIDTH){1'b0}}, w_op};
        end
    endgenerate

    // Only control[6:5] matters; the rest is folded here to keep lint quiet.
    assign w_unused = ^{req_control, w_op};

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            EMPTY: begin
                if (w_xfer) begin
                    w_state_nxt = FULL;
                end
            end
            FULL: begin
                if (w_xfer) begin
                    w_state_nxt = FULL;
                end else if (res_ready) begin
                    w_state_nxt = EMPTY;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr  <= '0;
            r_data <= '0;
            r_id   <= '0;
        end else if (w_xfer) begin
            r_ptr  <= rr_idx(w_gnt_idx, 1);
            r_data <= w_res;
            r_id   <= w_gnt_idx;
        end
    end

    assign busy      = (r_state == FULL);
    assign res_valid = busy;
    assign res_data  = r_data;
    assign res_id    = r_id;

endmodule

// File: tb/tb_logic_arbiter.sv
// Directed bench for logic_arbiter: hand-computed grants and results.
module tb_logic_arbiter;

    localparam int SW = 32;
    localparam int OW = 32;
    localparam int CW = 11;
    localparam int NR = 4;
    localparam int IW = 2;

    logic              clk;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*SW-1:0]  req_src1;
    logic [NR*SW-1:0]  req_src2;
    logic [NR*CW-1:0]  req_control;
    logic              res_valid;
    logic              res_ready;
    logic [OW-1:0]     res_data;
    logic [IW-1:0]     res_id;
    logic              busy;

    int n_cmp = 0;
    int n_err = 0;

    logic_arbiter #(
        .SRC_WIDTH(SW), .OUT_WIDTH(OW), .CONTROL_WIDTH(CW),
        .NUM_REQ(NR), .ID_WIDTH(IW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_src1(req_src1), .req_src2(req_src2),
        .req_control(req_control),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_id(res_id), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [SW-1:0] s1,
                           input logic [SW-1:0] s2, input logic [1:0] op);
        req_src1[i*SW +: SW]    = s1;
        req_src2[i*SW +: SW]    = s2;
        req_control[i*CW +: CW] = {4'b1001, op, 5'b10110};
    endtask

    task automatic chk_res(input string tag, input logic v,
                           input logic [OW-1:0] d, input logic [IW-1:0] id);
        chk({tag, ".valid"}, res_valid, v);
        chk({tag, ".busy"}, busy, v);
        chk({tag, ".data"}, res_data, d);
        chk({tag, ".id"}, res_id, id);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '1;
        res_ready = 1'b0;
        req_src1 = '0;
        req_src2 = '0;
        req_control = '0;
        tick();
        tick();
        chk("rst.ready", req_ready, 4'b0000);
        chk_res("rst", 1'b0, 32'h0, 2'd0);

        // single AND request from requester 0
        rst = 1'b0;
        req_valid = 4'b0001;
        res_ready = 1'b1;
        set_req(0, 32'hF0F0F0F0, 32'hFF00FF00, 2'd1);
        #1;
        chk("r0.ready", req_ready, 4'b0001);
        tick();
        chk_res("r0", 1'b1, 32'hF000F000, 2'd0);
        req_valid = '0;
        tick();
        chk_res("r0.drain", 1'b0, 32'hF000F000, 2'd0);

        // reset to ptr 0, then four requesters back-to-back
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NR; i++) begin
            set_req(i, 32'h11111111 * i, 32'hFFFFFFFF, 2'd1);
        end
        req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("rr%0d.ready", k), req_ready, 4'b0001 << (k % 4));
            tick();
            chk_res($sformatf("rr%0d", k), 1'b1,
                    32'h11111111 * (k % 4), 2'(k % 4));
        end

        // ptr is 2: requester 3 first, then requester 1
        set_req(3, 32'h33333333, 32'h0000000C, 2'd2);
        set_req(1, 32'hAAAAAAAA, 32'hAAAAAAAA, 2'd3);
        req_valid = 4'b1010;
        #1;
        chk("p2.ready3", req_ready, 4'b1000);
        tick();
        chk_res("p2.r3", 1'b1, 32'h3333333F, 2'd3);
        req_valid = 4'b0010;
        #1;
        chk("p2.ready1", req_ready, 4'b0010);
        tick();
        chk_res("p2.r1", 1'b1, 32'h0, 2'd1);
        req_valid = '0;
        tick();
        chk("p2.empty", busy, 1'b0);

        // NOT op with backpressure; a waiting requester must not be granted
        set_req(2, 32'h12345678, 32'h0000FFFF, 2'd0);
        req_valid = 4'b0100;
        res_ready = 1'b0;
        #1;
        chk("bp.ready2", req_ready, 4'b0100);
        tick();
        chk_res("bp.load", 1'b1, 32'hFFFF0000, 2'd2);
        req_valid = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("bp%0d.ready", k), req_ready, 4'b0000);
            tick();
            chk_res($sformatf("bp%0d", k), 1'b1, 32'hFFFF0000, 2'd2);
        end
        req_valid = '0;
        res_ready = 1'b1;
        tick();
        chk_res("bp.drain", 1'b0, 32'hFFFF0000, 2'd2);

        // ptr is 3; load requester 2 again, then reset while full
        req_valid = 4'b0100;
        res_ready = 1'b0;
        tick();
        chk_res("rf.load", 1'b1, 32'hFFFF0000, 2'd2);
        rst = 1'b1;
        req_valid = 4'b1111;
        #1;
        chk("rf.rst.ready", req_ready, 4'b0000);
        tick();
        rst = 1'b0;
        req_valid = 4'b1110;
        chk_res("rf.rst", 1'b0, 32'h0, 2'd0);
        #1;
        chk("rf.ptr0.ready", req_ready, 4'b0010);
        tick();
        chk_res("rf.r1", 1'b1, 32'h0, 2'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
